// File: rtl/day_tick_pkg.sv
// Shared definitions for the day tick controller: FSM state codes, rate-select codes,
// day range limits and the preset clamp helper.
package day_tick_pkg;

    typedef enum logic [1:0] {
        ST_PAUSE     = 2'b00,
        ST_RUN       = 2'b01,
        ST_STEP_HOLD = 2'b10,
        ST_LOAD      = 2'b11
    } state_t;

    localparam logic [1:0] RATE_1HZ   = 2'b00;
    localparam logic [1:0] RATE_2HZ   = 2'b01;
    localparam logic [1:0] RATE_10HZ  = 2'b10;
    localparam logic [1:0] RATE_100HZ = 2'b11;

    localparam logic [6:0] DAY_MIN = 7'd1;
    localparam logic [6:0] DAY_MAX = 7'd99;

    function automatic logic [6:0] clamp_day(input logic [6:0] value);
        logic [6:0] result;
        if (value == 7'd0) begin
            result = DAY_MIN;
        end else if (value > DAY_MAX) begin
            result = DAY_MAX;
        end else begin
            result = value;
        end
        return result;
    endfunction

    function automatic int rate_hz(input logic [1:0] sel);
        int hz;
        case (sel)
            RATE_1HZ:   hz = 1;
            RATE_2HZ:   hz = 2;
            RATE_10HZ:  hz = 10;
            RATE_100HZ: hz = 100;
            default:    hz = 1;
        endcase
        return hz;
    endfunction

endpackage

// File: rtl/day_tick_controller_debounce.sv
// Step-key conditioner: 2-flop synchronizer, stability counter and a one-cycle
// press event on each accepted 1->0 transition of the active-low key.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 200_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_key_level,
    output logic o_press
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;

    // Counter only runs while the synchronized key disagrees with the accepted level
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_press <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_key_n};
            if (r_sync[1] == r_level) begin
                r_cnt   <= '0;
                r_press <= 1'b0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_press <= ~r_sync[1];
            end else begin
                r_cnt   <= r_cnt + CW'(1);
                r_press <= 1'b0;
            end
        end
    end

    assign o_key_level = r_level;
    assign o_press     = r_press;

endmodule

// File: rtl/day_tick_controller.sv
// Day counter sequencer: free-run / pause / single-step / preset-load control
// producing registered one-cycle tick and load strobes.
module day_tick_controller
    import day_tick_pkg::*;
#(
    parameter int CLK_HZ          = 10_000_000,
    parameter int DEBOUNCE_CYCLES = 200_000
) (
    input  logic       ADC_CLK_10,
    input  logic       reset,
    input  logic       key_step_n,
    input  logic       sw_run,
    input  logic       sw_load,
    input  logic [1:0] sw_rate,
    input  logic [6:0] sw_preset,
    output logic       day_tick,
    output logic       load_pulse,
    output logic [6:0] load_value,
    output logic       running,
    output logic [1:0] state_o
);

    localparam int            PW         = $clog2(CLK_HZ);
    localparam logic [PW-1:0] TERM_1HZ   = PW'(CLK_HZ / rate_hz(RATE_1HZ) - 1);
    localparam logic [PW-1:0] TERM_2HZ   = PW'(CLK_HZ / rate_hz(RATE_2HZ) - 1);
    localparam logic [PW-1:0] TERM_10HZ  = PW'(CLK_HZ / rate_hz(RATE_10HZ) - 1);
    localparam logic [PW-1:0] TERM_100HZ = PW'(CLK_HZ / rate_hz(RATE_100HZ) - 1);

    logic [1:0]    r_rst_sync;
    logic          r_run_m, r_run_s;
    logic          r_load_m, r_load_s;
    logic [1:0]    r_rate_m, r_rate_s, r_rate_prev;
    logic [6:0]    r_preset_m, r_preset_s;
    logic [PW-1:0] r_presc;
    state_t        r_state;
    logic          r_day_tick;
    logic          r_load_pulse;
    logic [6:0]    r_load_value;
    logic          r_running;

    logic          w_key_level;
    logic          w_press;
    logic          w_rate_chg;
    logic          w_wrap;
    logic [PW-1:0] w_term;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .i_clk      (ADC_CLK_10),
        .i_rst_n    (reset),
        .i_key_n    (key_step_n),
        .o_key_level(w_key_level),
        .o_press    (w_press)
    );

    // Two-flop synchronizers for switches and for the reset release
    always_ff @(posedge ADC_CLK_10 or negedge reset) begin
        if (!reset) begin
            r_rst_sync  <= 2'b00;
            r_run_m     <= 1'b0;
            r_run_s     <= 1'b0;
            r_load_m    <= 1'b0;
            r_load_s    <= 1'b0;
            r_rate_m    <= 2'b00;
            r_rate_s    <= 2'b00;
            r_rate_prev <= 2'b00;
            r_preset_m  <= 7'd0;
            r_preset_s  <= 7'd0;
        end else begin
            r_rst_sync  <= {r_rst_sync[0], 1'b1};
            r_run_m     <= sw_run;
            r_run_s     <= r_run_m;
            r_load_m    <= sw_load;
            r_load_s    <= r_load_m;
            r_rate_m    <= sw_rate;
            r_rate_s    <= r_rate_m;
            r_rate_prev <= r_rate_s;
            r_preset_m  <= sw_preset;
            r_preset_s  <= r_preset_m;
        end
    end

    // Terminal count for the currently selected tick rate
    always_comb begin
        w_term = TERM_1HZ;
        case (r_rate_s)
            RATE_1HZ:   w_term = TERM_1HZ;
            RATE_2HZ:   w_term = TERM_2HZ;
            RATE_10HZ:  w_term = TERM_10HZ;
            RATE_100HZ: w_term = TERM_100HZ;
            default:    w_term = TERM_1HZ;
        endcase
    end

    assign w_rate_chg = (r_rate_s != r_rate_prev);
    assign w_wrap     = (r_state == ST_RUN) && !w_rate_chg && (r_presc == w_term);

    // Prescaler runs only in RUN; a rate change restarts the period without a strobe
    always_ff @(posedge ADC_CLK_10 or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
        end else if ((r_state != ST_RUN) || w_rate_chg || w_wrap) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Control FSM with registered strobes; load always pre-empts a tick
    always_ff @(posedge ADC_CLK_10 or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_PAUSE;
            r_day_tick   <= 1'b0;
            r_load_pulse <= 1'b0;
            r_load_value <= DAY_MIN;
            r_running    <= 1'b0;
        end else if (!r_rst_sync[1]) begin
            r_state      <= ST_PAUSE;
            r_day_tick   <= 1'b0;
            r_load_pulse <= 1'b0;
            r_running    <= 1'b0;
        end else begin
            r_day_tick   <= 1'b0;
            r_load_pulse <= 1'b0;
            case (r_state)
                ST_PAUSE, ST_RUN, ST_STEP_HOLD: begin
                    if (r_load_s) begin
                        r_state      <= ST_LOAD;
                        r_load_pulse <= 1'b1;
                        r_load_value <= clamp_day(r_preset_s);
                        r_running    <= 1'b0;
                    end else if (r_state == ST_PAUSE) begin
                        if (r_run_s) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end else if (w_press) begin
                            r_state    <= ST_STEP_HOLD;
                            r_day_tick <= 1'b1;
                        end else begin
                            r_state <= ST_PAUSE;
                        end
                    end else if (r_state == ST_RUN) begin
                        if (!r_run_s) begin
                            r_state   <= ST_PAUSE;
                            r_running <= 1'b0;
                        end else begin
                            r_day_tick <= w_wrap;
                            r_running  <= 1'b1;
                        end
                    end else begin
                        if (w_key_level) begin
                            r_state <= ST_PAUSE;
                        end else begin
                            r_state <= ST_STEP_HOLD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (r_load_s) begin
                        r_state <= ST_LOAD;
                    end else if (r_run_s) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end else begin
                        r_state <= ST_PAUSE;
                    end
                end
                default: begin
                    r_state   <= ST_PAUSE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign day_tick   = r_day_tick;
    assign load_pulse = r_load_pulse;
    assign load_value = r_load_value;
    assign running    = r_running;
    assign state_o    = r_state;

endmodule
